// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared constants for the SDRAM port arbiter
package dram_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_CPU   = 2'd1;
    localparam arb_state_t ST_DMA   = 2'd2;
    localparam arb_state_t ST_DRAIN = 2'd3;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/dram_wb_arbiter_if.sv
// rtl/dram_wb_arbiter_if.sv - CPU, DMA and SDRAM Wishbone signals around the arbiter
interface dram_wb_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]        m0_sel_i;
    logic [ADDR_W-1:0] m0_adr_i;
    logic [DATA_W-1:0] m0_dat_i;
    logic              m0_ack_o, m0_err_o;
    logic [DATA_W-1:0] m0_dat_o;

    logic              m1_cyc_i, m1_stb_i, m1_we_i;
    logic [ADDR_W-1:0] m1_adr_i;
    logic [1:0]        m1_fun_sel_i;
    logic              m1_ack_o, m1_err_o, m1_burst_en_o;
    logic [DATA_W-1:0] m1_dat_o;

    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]        s_sel_o;
    logic [ADDR_W-1:0] s_adr_o;
    logic [DATA_W-1:0] s_dat_o;
    logic [1:0]        s_fun_sel_o;
    logic              s_ack_i, s_burst_en_i;
    logic [DATA_W-1:0] s_dat_i;

    logic [1:0]        grant_o;

    // The arbiter is the slave both masters target
    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        output m0_ack_o, m0_err_o, m0_dat_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_fun_sel_i,
        output m1_ack_o, m1_err_o, m1_burst_en_o, m1_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_fun_sel_o,
        input  s_ack_i, s_burst_en_i, s_dat_i,
        output grant_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        input  m0_ack_o, m0_err_o, m0_dat_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_fun_sel_i,
        input  m1_ack_o, m1_err_o, m1_burst_en_o, m1_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_fun_sel_o,
        output s_ack_i, s_burst_en_i, s_dat_i,
        input  grant_o
    );

endinterface

// File: rtl/dram_arb_watchdog.sv
// rtl/dram_arb_watchdog.sv - saturating stall counter that flags a slave that never acks
module dram_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int              CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && cnt != LIMIT) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = en & (cnt == LIMIT);

endmodule

// File: rtl/dram_wb_arbiter.sv
// rtl/dram_wb_arbiter.sv - round-robin CPU/DMA arbiter in front of the single SDRAM controller port
module dram_wb_arbiter
    import dram_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    dram_wb_arbiter_if.slave bus
);
    arb_state_t state, state_nxt, st;
    logic       last_r, last_nxt;
    logic       m0_req, m1_req, stb_mux, expire, wd_clr;

    // Outputs decode from st so a reset blanks them in the cycle it is asserted
    assign st      = wb_rst_i ? ST_IDLE : state;
    assign m0_req  = bus.m0_cyc_i & bus.m0_stb_i;
    assign m1_req  = bus.m1_cyc_i & bus.m1_stb_i;
    assign stb_mux = (st == ST_CPU) ? bus.m0_stb_i :
                     (st == ST_DMA) ? bus.m1_stb_i : 1'b0;

    always_comb begin
        state_nxt = state;
        last_nxt  = last_r;
        case (state)
            ST_IDLE: begin
                if (m0_req && (!m1_req || last_r == OWN_DMA)) begin
                    state_nxt = ST_CPU;
                    last_nxt  = OWN_CPU;
                end else if (m1_req) begin
                    state_nxt = ST_DMA;
                    last_nxt  = OWN_DMA;
                end
            end
            ST_CPU: begin
                if (bus.s_ack_i || expire || !bus.m0_cyc_i) state_nxt = ST_IDLE;
            end
            ST_DMA: begin
                // An abort beats a pending burst: the data is untrustworthy
                if (expire)              state_nxt = ST_IDLE;
                else if (!bus.m1_cyc_i)  state_nxt = bus.s_burst_en_i ? ST_DRAIN : ST_IDLE;
            end
            default: begin
                if (!bus.s_burst_en_i) state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state  <= ST_IDLE;
            last_r <= OWN_DMA;
        end else begin
            state  <= state_nxt;
            last_r <= last_nxt;
        end
    end

    assign wd_clr = bus.s_ack_i | (state_nxt != state) | (st != ST_CPU && st != ST_DMA);

    dram_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (wd_clr),
        .en     (stb_mux & ~bus.s_ack_i),
        .expire (expire)
    );

    always_comb begin
        bus.s_cyc_o       = 1'b0;
        bus.s_stb_o       = stb_mux;
        bus.s_we_o        = 1'b0;
        bus.s_sel_o       = 4'h0;
        bus.s_adr_o       = '0;
        bus.s_dat_o       = '0;
        bus.s_fun_sel_o   = 2'b00;
        bus.m0_ack_o      = 1'b0;
        bus.m0_err_o      = 1'b0;
        bus.m0_dat_o      = '0;
        bus.m1_ack_o      = 1'b0;
        bus.m1_err_o      = 1'b0;
        bus.m1_burst_en_o = 1'b0;
        bus.m1_dat_o      = '0;
        bus.grant_o       = 2'b00;
        case (st)
            ST_CPU: begin
                bus.s_cyc_o  = bus.m0_cyc_i;
                bus.s_we_o   = bus.m0_we_i;
                bus.s_sel_o  = bus.m0_sel_i;
                bus.s_adr_o  = bus.m0_adr_i;
                bus.s_dat_o  = bus.m0_dat_i;
                bus.m0_ack_o = bus.s_ack_i;
                bus.m0_err_o = expire;
                bus.m0_dat_o = bus.s_dat_i;
                bus.grant_o  = 2'b01;
            end
            ST_DMA: begin
                bus.s_cyc_o       = bus.m1_cyc_i;
                bus.s_we_o        = bus.m1_we_i;
                bus.s_sel_o       = 4'hF;
                bus.s_adr_o       = bus.m1_adr_i;
                bus.s_fun_sel_o   = bus.m1_fun_sel_i;
                bus.m1_ack_o      = bus.s_ack_i;
                bus.m1_err_o      = expire;
                bus.m1_burst_en_o = bus.s_burst_en_i;
                bus.m1_dat_o      = bus.s_dat_i;
                bus.grant_o       = 2'b10;
            end
            ST_DRAIN: begin
                bus.m1_burst_en_o = bus.s_burst_en_i;
                bus.m1_dat_o      = bus.s_dat_i;
                bus.grant_o       = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/dram_wb_arbiter.md
# dram_wb_arbiter

Two-master Wishbone arbiter that shares the single SDRAM controller port between the Caravel CPU path (single-word read/write) and the DMA prefetch engine (burst reads feeding the accelerator). Sits between both masters and the SDRAM controller. Round-robin grants per transaction. A DRAIN state keeps a DMA burst intact after the DMA drops `cyc`. A watchdog converts a stalled slave into a one-cycle error to the owning master.

## Interface
- `TIMEOUT`, 255: cycles a granted `stb` may wait for `s_ack_i` before abort.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `wb_clk_i` in 1: the only clock.
- `wb_rst_i` in 1: reset; synchronous, active-high.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: CPU request.
- `m0_sel_i` in 4: CPU byte select.
- `m0_adr_i` in ADDR_W: CPU address.
- `m0_dat_i` in DATA_W: CPU write data.
- `m0_ack_o`, `m0_err_o` out 1 each: CPU completion / abort.
- `m0_dat_o` out DATA_W: CPU read data.
- `m1_cyc_i`, `m1_stb_i`, `m1_we_i` in 1 each: DMA request.
- `m1_adr_i` in ADDR_W: DMA address.
- `m1_fun_sel_i` in 2: DMA function select.
- `m1_ack_o`, `m1_err_o`, `m1_burst_en_o` out 1 each: DMA completion / abort / burst-valid.
- `m1_dat_o` out DATA_W: DMA burst data.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: to SDRAM controller.
- `s_sel_o` out 4: byte select to SDRAM.
- `s_adr_o` out ADDR_W: address to SDRAM.
- `s_dat_o` out DATA_W: write data to SDRAM.
- `s_fun_sel_o` out 2: function select to SDRAM.
- `s_ack_i`, `s_burst_en_i` in 1 each: SDRAM ack / burst-valid.
- `s_dat_i` in DATA_W: SDRAM read data.
- `grant_o` out 2: one-hot owner (bit0 CPU, bit1 DMA); 0 when idle.

## Operation
- FSM states: IDLE, CPU, DMA, DRAIN. Reset state is IDLE.
- Registers: `last_r`. It resets to DMA, so the CPU wins the first tie.
- IDLE → CPU when `m0_cyc_i & m0_stb_i` and either the DMA is not requesting or `last_r`=DMA.
- IDLE → DMA in the symmetric case. On the grant transition, `last_r` takes the new owner.
- CPU → IDLE on `s_ack_i`, on watchdog expiry, or when `m0_cyc_i` drops.
- DMA → DRAIN when `m1_cyc_i` is low and `s_burst_en_i` is high.
- DMA → IDLE when `m1_cyc_i` is low and `s_burst_en_i` is low, or on watchdog expiry.
- DRAIN → IDLE when `s_burst_en_i` is low.
- Slave outputs are muxed combinationally from the owner's inputs, and are forced to 0 in IDLE and DRAIN.
- `s_sel_o` is tied to 4'hF for the DMA. `s_fun_sel_o` is 0 for the CPU.
- `s_ack_i` and `s_dat_i` are routed to the owner only. The non-owner sees ack=0 and dat=0.
- `s_burst_en_i` reaches `m1_burst_en_o` only in DMA or DRAIN. Otherwise `m1_burst_en_o`=0.
- Watchdog: counts cycles in CPU/DMA with `s_stb_o` high and `s_ack_i` low. It clears on ack, on state change, and in IDLE.
- When the count reaches `TIMEOUT`, the owner's `err_o` pulses for exactly 1 cycle and the FSM goes to IDLE.
- Counter width is clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- Reset values: all `s_*_o`, `m*_ack_o`, `m*_err_o`, `m1_burst_en_o`, `grant_o` = 0. Data outputs = 0.
- Grant latency: request sampled in IDLE at cycle n → `grant_o` and `s_stb_o` valid at cycle n+1.
- At least one IDLE cycle separates consecutive grants, including back-to-back requests by the same master.
- Ack pass-through is combinational, with zero added latency.
- Simultaneous first requests from both masters in IDLE: the one that is not `last_r` wins. The loser stays pending with no ack.
- A request that arrives while DRAIN is active waits until DRAIN exits plus the IDLE cycle.
- Reset asserted mid-grant or mid-DRAIN: next edge returns to IDLE and `last_r`=DMA. Outputs are 0 the same cycle, because they are decoded from state.
- `err_o` and `ack_o` are never high in the same cycle. An ack that arrives on the expiry cycle wins, and no error is raised.

## Structure
- Package `dram_arb_pkg`:
  - state enum (IDLE/CPU/DMA/DRAIN);
  - owner constants OWN_CPU=0 and OWN_DMA=1;
  - default `TIMEOUT`.
- Sub-module `dram_arb_watchdog`: saturating counter with clear/enable inputs and an `expire` pulse output.
- FSM, round-robin logic and muxes live in the top level.

## Test plan
- CPU read alone, `m0_adr_i`=0x3800_0010, slave acks 3 cycles after `s_stb_o` → `grant_o`=01 one cycle after request; `m0_ack_o` with `m0_dat_o`=`s_dat_i`=0xDEAD_BEEF; back to IDLE.
- Both request in the same cycle after reset → CPU granted first. After CPU ack plus 1 idle cycle, DMA granted. Next tie goes to CPU again.
- DMA read: `s_ack_i`, DMA drops `cyc`, then 4 cycles of `s_burst_en_i` with data 1..4 → DRAIN for 4 cycles and `m1_dat_o` shows 1..4. CPU request raised during the burst is granted only after `s_burst_en_i` falls plus 1 cycle.
- `TIMEOUT`=8, slave never acks a CPU write → `m0_err_o` high for exactly one cycle, 8 cycles after `s_stb_o` rises; then IDLE and DMA can be granted.
- `wb_rst_i` pulsed during DRAIN → all outputs 0 the next cycle; a subsequent tie grants CPU.
